// File: rtl/qrisc32_avm_arbiter_pkg.sv
// Shared types and constants for the qrisc32 three-port Avalon arbiter.
package qrisc32_avm_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    localparam logic [1:0] ARB_PORT_INSTR = 2'd0;
    localparam logic [1:0] ARB_PORT_DATAR = 2'd1;
    localparam logic [1:0] ARB_PORT_DATAW = 2'd2;

    // Next port in the fixed 0 -> 1 -> 2 -> 0 search ring.
    function automatic logic [1:0] arb_next_port(input logic [1:0] p);
        return (p == ARB_PORT_DATAW) ? ARB_PORT_INSTR : p + 2'd1;
    endfunction

endpackage

// File: rtl/qrisc32_avm_arbiter_if.sv
// Bundle of the three CPU-side Avalon ports, the shared memory port and status.
interface qrisc32_avm_arbiter_if;
    import qrisc32_avm_arbiter_pkg::*;

    // Handshake: a master holds rd/wr with stable addr/data while wait_req=1;
    // the transfer completes on the rising edge where request and wait_req=0 coexist.
    logic [31:0] s_instr_addr;
    logic        s_instr_rd;
    logic [31:0] s_instr_data;
    logic        s_instr_wait_req;

    logic [31:0] s_datar_addr;
    logic        s_datar_rd;
    logic [31:0] s_datar_data;
    logic        s_datar_wait_req;

    logic [31:0] s_dataw_addr;
    logic [31:0] s_dataw_data;
    logic        s_dataw_wr;
    logic        s_dataw_wait_req;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wait_req;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    logic        err_timeout;
    arb_state_t  dbg_state;

    modport slave (
        input  s_instr_addr, s_instr_rd,
        output s_instr_data, s_instr_wait_req,
        input  s_datar_addr, s_datar_rd,
        output s_datar_data, s_datar_wait_req,
        input  s_dataw_addr, s_dataw_data, s_dataw_wr,
        output s_dataw_wait_req,
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_wait_req, mem_rdata, mem_rdata_valid,
        output err_timeout, dbg_state
    );

    modport master (
        output s_instr_addr, s_instr_rd,
        input  s_instr_data, s_instr_wait_req,
        output s_datar_addr, s_datar_rd,
        input  s_datar_data, s_datar_wait_req,
        output s_dataw_addr, s_dataw_data, s_dataw_wr,
        input  s_dataw_wait_req,
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_wait_req, mem_rdata, mem_rdata_valid,
        input  err_timeout, dbg_state
    );

endinterface

// File: rtl/qrisc32_rr_arbiter.sv
// Three-way round-robin picker; the pointer remembers the last winner.
module qrisc32_rr_arbiter
    import qrisc32_avm_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       areset,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [2:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] ptr;
    logic [1:0] cand;
    logic       found;

    // Reset to the last port so instr is searched first.
    always_ff @(posedge clk) begin
        if (areset) begin
            ptr <= ARB_PORT_DATAW;
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

    always_comb begin
        grant     = 3'b000;
        grant_idx = ARB_PORT_INSTR;
        found     = 1'b0;
        cand      = ptr;
        for (int k = 0; k < 3; k++) begin
            cand = arb_next_port(cand);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qrisc32_avm_arbiter.sv
// Merges qrisc32 instr-read, data-read and data-write Avalon masters onto one
// memory master, one transaction in flight, round-robin granted.
module qrisc32_avm_arbiter
    import qrisc32_avm_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 areset,
    qrisc32_avm_arbiter_if.slave bus
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state_q, state_d;
    logic [1:0]    port_q, port_d;
    logic          is_write_q, is_write_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    logic [2:0]    wait_req_q, wait_req_d;
    logic [31:0]   instr_data_q, instr_data_d;
    logic [31:0]   datar_data_q, datar_data_d;

    logic [2:0]    req;
    logic [2:0]    grant;
    logic [1:0]    grant_idx;
    logic          advance;
    logic          cap_en;
    logic [31:0]   cap_word;

    assign req = {bus.s_dataw_wr, bus.s_datar_rd, bus.s_instr_rd};

    qrisc32_rr_arbiter u_rr (
        .clk       (clk),
        .areset    (areset),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= ARB_IDLE;
            port_q       <= ARB_PORT_INSTR;
            is_write_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
            wait_req_q   <= 3'b111;
            instr_data_q <= '0;
            datar_data_q <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            is_write_q   <= is_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
            wait_req_q   <= wait_req_d;
            instr_data_q <= instr_data_d;
            datar_data_q <= datar_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        is_write_d   = is_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = err_q;
        wait_req_d   = 3'b111;
        instr_data_d = instr_data_q;
        datar_data_d = datar_data_q;
        advance      = 1'b0;
        cap_en       = 1'b0;
        cap_word     = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    advance    = 1'b1;
                    port_d     = grant_idx;
                    is_write_d = grant[ARB_PORT_DATAW];
                    if (grant[ARB_PORT_DATAW]) begin
                        mem_addr_d  = bus.s_dataw_addr;
                        mem_wdata_d = bus.s_dataw_data;
                    end else if (grant[ARB_PORT_DATAR]) begin
                        mem_addr_d  = bus.s_datar_addr;
                    end else begin
                        mem_addr_d  = bus.s_instr_addr;
                    end
                    mem_rd_d = !grant[ARB_PORT_DATAW];
                    mem_wr_d = grant[ARB_PORT_DATAW];
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (!bus.mem_wait_req) begin
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    tmo_cnt_d = '0;
                    if (is_write_q) begin
                        wait_req_d[port_q] = 1'b0;
                        state_d            = ARB_DONE;
                    end else begin
                        state_d = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                // Valid data on the final timeout cycle still wins over the timeout.
                if (bus.mem_rdata_valid) begin
                    cap_en   = 1'b1;
                    cap_word = bus.mem_rdata;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    cap_en = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
                if (cap_en) begin
                    wait_req_d[port_q] = 1'b0;
                    state_d            = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (cap_en) begin
            if (port_q == ARB_PORT_INSTR) begin
                instr_data_d = cap_word;
            end else begin
                datar_data_d = cap_word;
            end
        end
    end

    assign bus.mem_addr         = mem_addr_q;
    assign bus.mem_wdata        = mem_wdata_q;
    assign bus.mem_rd           = mem_rd_q;
    assign bus.mem_wr           = mem_wr_q;
    assign bus.s_instr_data     = instr_data_q;
    assign bus.s_datar_data     = datar_data_q;
    assign bus.s_instr_wait_req = wait_req_q[ARB_PORT_INSTR];
    assign bus.s_datar_wait_req = wait_req_q[ARB_PORT_DATAR];
    assign bus.s_dataw_wait_req = wait_req_q[ARB_PORT_DATAW];
    assign bus.err_timeout      = err_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_qrisc32_avm_arbiter.sv
// Bench for qrisc32_avm_arbiter: memory model, per-port drivers, scoreboard monitor.
module tb_qrisc32_avm_arbiter;
    import qrisc32_avm_arbiter_pkg::*;

    localparam int TMO      = 8;
    localparam int XFER_MAX = 500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    qrisc32_avm_arbiter_if bus();

    qrisc32_avm_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_datar_q[$];
    logic [31:0] exp_dataw_q[$];
    logic [31:0] exp_waddr_q[$];
    int          done_order[$];

    // ---------------- memory model state ----------------
    logic [31:0] mem_model [logic [31:0]];
    int          stall_pct   = 0;
    int          force_stall = 0;
    int          rsp_lat     = 0;
    bit          rand_lat    = 1'b0;
    bit          drop_reads  = 1'b0;
    int          strobe_cycles = 0;
    int          stable_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Contents of memory: explicit writes/preloads, otherwise a fixed hash of the address.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic port_wait(input int p);
        case (p)
            0:       return bus.s_instr_wait_req;
            1:       return bus.s_datar_wait_req;
            default: return bus.s_dataw_wait_req;
        endcase
    endfunction

    // ---------------- memory model ----------------
    initial begin : mem_proc
        bit          rsp_pending;
        int          rsp_delay;
        logic [31:0] rsp_data;
        bit          in_cmd;
        logic [31:0] cmd_addr, cmd_wdata;
        rsp_pending = 1'b0;
        rsp_delay   = 0;
        rsp_data    = '0;
        in_cmd      = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        bus.mem_wait_req    = 1'b0;
        bus.mem_rdata       = '0;
        bus.mem_rdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_rdata_valid = 1'b0;
            if (rsp_pending) begin
                if (rsp_delay == 0) begin
                    bus.mem_rdata_valid = 1'b1;
                    bus.mem_rdata       = rsp_data;
                    rsp_pending         = 1'b0;
                end else begin
                    rsp_delay--;
                end
            end
            if (force_stall > 0 && (bus.mem_rd || bus.mem_wr)) begin
                bus.mem_wait_req = 1'b1;
                force_stall--;
            end else if (stall_pct > 0) begin
                bus.mem_wait_req = ($urandom_range(0, 99) < stall_pct);
            end else begin
                bus.mem_wait_req = 1'b0;
            end
            if (bus.mem_rd || bus.mem_wr) begin
                strobe_cycles++;
                if (!in_cmd) begin
                    in_cmd    = 1'b1;
                    cmd_addr  = bus.mem_addr;
                    cmd_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== cmd_addr || bus.mem_wdata !== cmd_wdata) begin
                    stable_errs++;
                end
                if (!bus.mem_wait_req) begin
                    in_cmd = 1'b0;
                    if (bus.mem_wr) begin
                        mem_model[bus.mem_addr] = bus.mem_wdata;
                    end else if (!drop_reads) begin
                        rsp_pending = 1'b1;
                        rsp_delay   = rand_lat ? int'($urandom_range(0, 4)) : rsp_lat;
                        rsp_data    = rd_word(bus.mem_addr);
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor_proc
        int          lows;
        logic [31:0] a, d;
        forever begin
            @(negedge clk);
            if (areset === 1'b0) begin
                lows = int'(!bus.s_instr_wait_req) + int'(!bus.s_datar_wait_req)
                     + int'(!bus.s_dataw_wait_req);
                if (lows != 0) check("single_done", 32'(lows), 32'd1);
                if (bus.s_instr_wait_req === 1'b0) begin
                    done_order.push_back(0);
                    check("instr_pending", 32'(exp_instr_q.size() > 0), 32'd1);
                    if (exp_instr_q.size() > 0) check("instr_data", bus.s_instr_data, exp_instr_q.pop_front());
                end
                if (bus.s_datar_wait_req === 1'b0) begin
                    done_order.push_back(1);
                    check("datar_pending", 32'(exp_datar_q.size() > 0), 32'd1);
                    if (exp_datar_q.size() > 0) check("datar_data", bus.s_datar_data, exp_datar_q.pop_front());
                end
                if (bus.s_dataw_wait_req === 1'b0) begin
                    done_order.push_back(2);
                    check("dataw_pending", 32'(exp_dataw_q.size() > 0), 32'd1);
                    if (exp_dataw_q.size() > 0) begin
                        a = exp_waddr_q.pop_front();
                        d = exp_dataw_q.pop_front();
                        check("dataw_landed", mem_model.exists(a) ? mem_model[a] : ~d, d);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left on a falling edge; returns falling edges until wait_req=0.
    task automatic xfer(input int p, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, output int lat);
        lat = 0;
        case (p)
            0: begin
                exp_instr_q.push_back(exp);
                bus.s_instr_addr = a;
                bus.s_instr_rd   = 1'b1;
            end
            1: begin
                exp_datar_q.push_back(exp);
                bus.s_datar_addr = a;
                bus.s_datar_rd   = 1'b1;
            end
            default: begin
                exp_dataw_q.push_back(wd);
                exp_waddr_q.push_back(a);
                bus.s_dataw_addr = a;
                bus.s_dataw_data = wd;
                bus.s_dataw_wr   = 1'b1;
            end
        endcase
        do begin
            @(negedge clk);
            lat++;
        end while (port_wait(p) !== 1'b0 && lat < XFER_MAX);
        if (port_wait(p) !== 1'b0) check($sformatf("xfer_done_p%0d", p), 32'(port_wait(p)), 32'd0);
        case (p)
            0:       bus.s_instr_rd = 1'b0;
            1:       bus.s_datar_rd = 1'b0;
            default: bus.s_dataw_wr = 1'b0;
        endcase
    endtask

    task automatic reset_pulse();
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_rd"},    32'(bus.mem_rd), 32'd0);
        check({tag, "_mem_wr"},    32'(bus.mem_wr), 32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_instr_data"}, bus.s_instr_data, 32'd0);
        check({tag, "_datar_data"}, bus.s_datar_data, 32'd0);
        check({tag, "_wait_reqs"}, {29'd0, bus.s_dataw_wait_req, bus.s_datar_wait_req,
                                    bus.s_instr_wait_req}, 32'd7);
        check({tag, "_err"},       32'(bus.err_timeout), 32'd0);
        check({tag, "_state"},     32'(bus.dbg_state), 32'(ARB_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at %0t, required completion before it", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, lat0, lat1, lat2;
        areset = 1'b1;
        bus.s_instr_addr = '0; bus.s_instr_rd = 1'b0;
        bus.s_datar_addr = '0; bus.s_datar_rd = 1'b0;
        bus.s_dataw_addr = '0; bus.s_dataw_data = '0; bus.s_dataw_wr = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        areset = 1'b0;
        repeat (2) @(negedge clk);

        // Single instr read with one-cycle memory latency.
        mem_model[32'h100] = 32'hA5A5_0001;
        strobe_cycles = 0;
        xfer(0, 32'h100, '0, 32'hA5A5_0001, lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_rd_cycles", 32'(strobe_cycles), 32'd1);
        repeat (2) @(negedge clk);
        check("t1_data_hold", bus.s_instr_data, 32'hA5A5_0001);
        check("t1_wait_back", 32'(bus.s_instr_wait_req), 32'd1);

        // Write with three stall cycles from memory.
        force_stall = 3; strobe_cycles = 0; stable_errs = 0;
        xfer(2, 32'h200, 32'h1234_5678, '0, lat);
        check("t2_latency", 32'(lat), 32'd5);
        check("t2_wr_cycles", 32'(strobe_cycles), 32'd4);
        check("t2_stable", 32'(stable_errs), 32'd0);
        check("t2_mem", rd_word(32'h200), 32'h1234_5678);
        @(negedge clk);

        // All three ports requesting continuously from reset.
        reset_pulse();
        done_order.delete();
        fork
            for (int k = 0; k < 3; k++) xfer(0, 32'h1000_0000 + 32'(k * 4), '0, rd_word(32'h1000_0000 + 32'(k * 4)), lat0);
            for (int k = 0; k < 3; k++) xfer(1, 32'h1100_0000 + 32'(k * 4), '0, rd_word(32'h1100_0000 + 32'(k * 4)), lat1);
            for (int k = 0; k < 3; k++) xfer(2, 32'h2000_0000 + 32'(k * 4), $urandom, '0, lat2);
        join
        check("t3_count", 32'(done_order.size()), 32'd9);
        for (int i = 0; i < done_order.size() && i < 9; i++)
            check($sformatf("t3_order_%0d", i), 32'(done_order[i]), 32'(i % 3));
        @(negedge clk);

        // Read that never gets data, then a normal read.
        drop_reads = 1'b1;
        xfer(1, 32'h300, '0, 32'd0, lat);
        check("t4_tmo_latency", 32'(lat), 32'(TMO + 2));
        check("t4_err_set", 32'(bus.err_timeout), 32'd1);
        drop_reads = 1'b0;
        @(negedge clk);
        xfer(1, 32'h1100_0100, '0, rd_word(32'h1100_0100), lat);
        check("t4_next_latency", 32'(lat), 32'd3);
        check("t4_err_sticky", 32'(bus.err_timeout), 32'd1);
        @(negedge clk);

        // Reset during WAIT with a late response still in flight.
        rsp_lat = 5;
        bus.s_instr_addr = 32'h400;
        bus.s_instr_rd   = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_in_wait", 32'(bus.dbg_state), 32'(ARB_WAIT));
        bus.s_instr_rd = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        check_reset("t5");
        areset = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_no_late_data", bus.s_instr_data, 32'd0);
        check("t5_still_idle", 32'(bus.dbg_state), 32'(ARB_IDLE));
        rsp_lat = 0;
        done_order.delete();
        fork
            xfer(0, 32'h1000_0040, '0, rd_word(32'h1000_0040), lat0);
            xfer(1, 32'h1100_0040, '0, rd_word(32'h1100_0040), lat1);
            xfer(2, 32'h2000_0040, $urandom, '0, lat2);
        join
        check("t5_count", 32'(done_order.size()), 32'd3);
        if (done_order.size() > 0) check("t5_instr_first", 32'(done_order[0]), 32'd0);
        @(negedge clk);

        // Random stall / latency soak.
        stall_pct = 30;
        rand_lat  = 1'b1;
        fork
            for (int k = 0; k < 20; k++) begin
                logic [31:0] a;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
                xfer(0, a, '0, rd_word(a), lat0);
            end
            for (int k = 0; k < 20; k++) begin
                logic [31:0] a;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                a = 32'h5000_0000 | ($urandom & 32'h0000_FFFC);
                xfer(1, a, '0, rd_word(a), lat1);
            end
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                xfer(2, 32'h3000_0000 + 32'(k * 4), $urandom, '0, lat2);
            end
        join
        repeat (3) @(negedge clk);
        check("soak_err_clear", 32'(bus.err_timeout), 32'd0);
        check("queues_empty", 32'(exp_instr_q.size() + exp_datar_q.size() + exp_dataw_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
